fft_frame_capture: RTL and testbench
====================================

# fft_frame_capture

Single-clock frame buffer between the FFT result stream and the MCU UART link. On an MCU request (`rx_ready`) it waits for the start of an FFT frame and captures exactly `FRAME_LEN` samples into internal RAM. It then drains the frame to the UART transmitter over a valid/ready handshake, and returns to idle only after the MCU releases its request. It is the parametrised successor of the current FIFO control path: configurable width and depth, frame alignment, abort handling, and no external FIFO core.

## Interface
Parameters:
- `DATA_W`, 32: sample width, signed two's complement.
- `FRAME_LEN`, 1024: samples per frame; must be at least 2; need not be a power of two.
- `CNT_W`, `$clog2(FRAME_LEN+1)`: width of count outputs; derived, do not override.

Ports:
- `clk` in 1: system clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rx_ready` in 1: MCU request level.
- `in_valid` in 1: FFT sample strobe.
- `in_sop` in 1: first bin of a frame; qualified by `in_valid`.
- `in_data` in `DATA_W`: FFT sample, signed.
- `out_ready` in 1: UART can accept a word.
- `out_valid` out 1: `out_data` is valid.
- `out_data` out `DATA_W`: drained sample.
- `out_last` out 1: marks the final word of the frame; qualified by `out_valid`.
- `uart_en` out 1: high throughout DRAIN.
- `fill_count` out `CNT_W`: samples written so far in the current frame.
- `frame_done` out 1: one-cycle pulse when the last word is accepted.
- `abort` out 1: one-cycle pulse when a request is dropped mid-frame.

## Operation
- Reset values: state IDLE; `out_valid`, `out_last`, `uart_en`, `frame_done`, `abort` = 0; `out_data` = 0; `fill_count` = 0; write and read pointers = 0.
- States are IDLE, ARM, FILL, DRAIN, HOLD; one-hot encoded.
- IDLE: when `rx_ready`=1, go to ARM.
- ARM: samples without `in_sop` are ignored. On `in_valid & in_sop`, write the sample to address 0, set `fill_count` to 1, and go to FILL.
  - If `FRAME_LEN` were 1 this would go straight to DRAIN; that case is excluded by the parameter rule.
- FILL: each `in_valid` writes `in_data` to address `fill_count` and increments `fill_count`.
  - `in_valid & in_sop` in FILL restarts the frame: the sample is written to address 0 and `fill_count` becomes 1. No pulse is raised.
  - The write that brings `fill_count` to `FRAME_LEN` moves the state to DRAIN. Further input is ignored until the next ARM.
- DRAIN: words 0 to `FRAME_LEN`-1 are presented in order. `uart_en`=1.
  - A word is accepted on `out_valid & out_ready`.
  - `out_last`=1 with word `FRAME_LEN`-1.
  - Acceptance of the last word pulses `frame_done`, clears `out_valid`, and moves to HOLD.
- HOLD: wait for `rx_ready`=0, then go to IDLE. One frame is sent per request.
- Abort: `rx_ready`=0 while in ARM, FILL or DRAIN returns the state to IDLE next cycle.
  - `abort` pulses for 1 cycle. It does not pulse when leaving ARM, because no data has been taken there.
  - `out_valid` and `uart_en` clear at the same edge. `fill_count` clears.
- RAM: `FRAME_LEN` × `DATA_W`, one write port and one synchronous read port. Inferred, not instantiated.

## Timing
- Fill: `fill_count` updates on the edge after `in_valid`.
- The state is DRAIN one cycle after the final write. `out_valid`=1 with word 0 two cycles after the final write (one cycle of read latency).
- Throughput: with `out_ready` held at 1, one word is delivered per cycle. Read-ahead uses the address `rd_ptr + (out_valid & out_ready)`.
- Stall: while `out_valid & !out_ready`, `out_data` and `out_last` hold stable.
- `frame_done` is asserted in the cycle after the last handshake, coincident with `out_valid` falling.
- If an abort and an `in_valid` arrive in the same cycle, the abort wins and no write occurs.
- Asynchronous reset mid-frame drops all outputs immediately, and the buffer contents are discarded.

## Configuration
- `FFT_CAPTURE_ABS_EN` defined: `out_data` carries the absolute value of the stored sample.
  - The most negative value (-2^(`DATA_W`-1)) saturates to 2^(`DATA_W`-1)-1.
  - The conversion is combinational on the read-register output and adds no latency.
- `FFT_CAPTURE_ABS_EN` not defined: `out_data` is the raw signed sample.

## Test plan
- Basic frame (`FRAME_LEN`=8): raise `rx_ready` and send 3 non-sop samples, then sop plus 7 samples with values 10..17. Required: the 3 leading samples are ignored. `out_valid` appears 2 cycles after the last write, and 10..17 drain back-to-back with `out_last` on 17. `frame_done` pulses once; HOLD is held until `rx_ready`=0.
- Backpressure: toggle `out_ready` every other cycle. Required: each word holds stable while stalled, 8 words are delivered with no loss or duplication, and `uart_en`=1 throughout.
- Restart: sop, 4 samples, then sop again followed by 8 samples. Required: `fill_count` returns to 1 and only the second frame is drained.
- Abort: drop `rx_ready` during FILL at `fill_count`=5, and separately during DRAIN after word 3. Required: `abort` pulses once each time, outputs clear the next cycle, and a fresh request captures a new frame correctly.
- Reset: assert `rst_n`=0 mid-DRAIN. Required: `out_valid`=0 immediately and all outputs return to their reset values.
- Macro: with `FFT_CAPTURE_ABS_EN` and `DATA_W`=8, input -5, 7, -128. Required output: 5, 7, 127. Without the macro: -5, 7, -128.

Source files
------------

// File: rtl/fft_frame_capture_if.sv
// Stream bundle for fft_frame_capture: FFT sample input and UART-side drain output.
// master: the side that feeds samples and consumes drained words.
// slave:  the frame buffer itself.
interface fft_frame_capture_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_sop;
  logic [DATA_W-1:0] in_data;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, in_sop, in_data, out_ready,
    input  out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_sop, in_data, out_ready,
    output out_valid, out_data, out_last
  );
endinterface

// File: rtl/fft_frame_capture.sv
// Frame buffer between the FFT result stream and the MCU UART link.
// On an MCU request it waits for a start-of-frame, captures FRAME_LEN samples
// into an inferred RAM, drains them over valid/ready, then holds until the
// request is released. Dropping the request mid-frame aborts back to idle.
// Optional feature: define FFT_CAPTURE_ABS_EN to output the saturated absolute
// value of each stored sample instead of the raw signed sample.
module fft_frame_capture #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 1024,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_ready,
  fft_frame_capture_if.slave   bus,
  output logic                 uart_en,
  output logic [CNT_W-1:0]     fill_count,
  output logic                 frame_done,
  output logic                 abort
);

  localparam int               AW   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [CNT_W-1:0] LEN  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ARM   = 5'b00010,
    FILL  = 5'b00100,
    DRAIN = 5'b01000,
    HOLD  = 5'b10000
  } state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] mem [FRAME_LEN];
  logic [DATA_W-1:0] rd_q;
  logic [CNT_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  rd_addr;
  logic [CNT_W-1:0]  fill_next;
  logic [AW-1:0]     wr_addr;
  logic              in_take;
  logic              hs;
  logic              last_hs;
  logic              drop;
  logic              abort_hit;
  logic              rd_load;

  // Losing the request always wins over any write or handshake in the same cycle.
  assign in_take   = bus.in_valid & rx_ready &
                     ((state == ARM) ? bus.in_sop : (state == FILL));
  assign fill_next = bus.in_sop ? CNT_W'(1) : fill_count + CNT_W'(1);
  assign wr_addr   = bus.in_sop ? '0 : fill_count[AW-1:0];
  assign hs        = bus.out_valid & bus.out_ready;
  assign last_hs   = (state == DRAIN) & rx_ready & hs & (rd_ptr == LAST);
  assign drop      = ~rx_ready & ((state == ARM) | (state == FILL) | (state == DRAIN));
  assign abort_hit = ~rx_ready & ((state == FILL) | (state == DRAIN));
  // Read-ahead: fetch the next word on acceptance so back-to-back delivery needs no bubble.
  assign rd_addr   = rd_ptr + CNT_W'(hs);
  assign rd_load   = (state == DRAIN) & rx_ready &
                     (~bus.out_valid | (hs & (rd_ptr != LAST)));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rx_ready) state_next = ARM;
      ARM:     if (!rx_ready) state_next = IDLE;
               else if (in_take) state_next = FILL;
      FILL:    if (!rx_ready) state_next = IDLE;
               else if (in_take && fill_next == LEN) state_next = DRAIN;
      DRAIN:   if (!rx_ready) state_next = IDLE;
               else if (last_hs) state_next = HOLD;
      HOLD:    if (!rx_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Fill counter: cleared whenever the machine heads back to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   fill_count <= '0;
    else if (state_next == IDLE)  fill_count <= '0;
    else if (in_take)             fill_count <= fill_next;
  end

  // Frame RAM write port.
  always_ff @(posedge clk) begin
    if (in_take) mem[wr_addr] <= bus.in_data;
  end

  // Synchronous read register feeding out_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_q <= '0;
    else if (rd_load) rd_q <= mem[rd_addr[AW-1:0]];
  end

  // Drain pointer and valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr        <= '0;
      bus.out_valid <= 1'b0;
    end else if (drop) begin
      rd_ptr        <= '0;
      bus.out_valid <= 1'b0;
    end else if (rd_load) begin
      rd_ptr        <= rd_addr;
      bus.out_valid <= 1'b1;
    end else if (last_hs) begin
      rd_ptr        <= '0;
      bus.out_valid <= 1'b0;
    end
  end

  // One-cycle status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      abort      <= 1'b0;
    end else begin
      frame_done <= last_hs;
      abort      <= abort_hit;
    end
  end

`ifdef FFT_CAPTURE_ABS_EN
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
`endif

  // Outputs decoded from state and the read register.
  always_comb begin
    uart_en      = (state == DRAIN);
    bus.out_last = bus.out_valid & (rd_ptr == LAST);
    bus.out_data = rd_q;
`ifdef FFT_CAPTURE_ABS_EN
    if (rd_q == MOST_NEG)     bus.out_data = MAX_POS;
    else if (rd_q[DATA_W-1])  bus.out_data = ~rd_q + DATA_W'(1);
`endif
  end

endmodule

// File: tb/tb_fft_frame_capture.sv
// Directed bench for fft_frame_capture (DATA_W=8, FRAME_LEN=8) with a
// queue-based frame model and a per-cycle output checker.
module tb_fft_frame_capture;
  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 8;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             rx_ready = 1'b0;
  logic             uart_en, frame_done, abort;
  logic [CNT_W-1:0] fill_count;

  fft_frame_capture_if #(.DATA_W(DATA_W)) bus ();

  fft_frame_capture #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .rx_ready(rx_ready), .bus(bus),
    .uart_en(uart_en), .fill_count(fill_count),
    .frame_done(frame_done), .abort(abort)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Frame model: ignore until sop, restart on sop, freeze once a frame is full.
  int cap[$];
  int exp_q[$];
  int got[$];
  bit cap_on, cap_full;
  int words_seen = 0;

  function automatic int conv(input int v);
`ifdef FFT_CAPTURE_ABS_EN
    int a;
    int mx;
    mx = (1 << (DATA_W - 1)) - 1;
    a  = (v < 0) ? -v : v;
    return (a > mx) ? mx : a;
`else
    return v;
`endif
  endfunction

  function automatic void model_req();
    cap.delete();
    cap_on   = 1'b0;
    cap_full = 1'b0;
  endfunction

  function automatic void model_in(input bit sop, input int v);
    if (cap_full) return;
    if (sop) begin
      cap.delete();
      cap_on = 1'b1;
    end
    if (!cap_on) return;
    cap.push_back(v);
    if (cap.size() == FRAME_LEN) begin
      cap_full = 1'b1;
      foreach (cap[i]) exp_q.push_back(conv(cap[i]));
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sop, input int v);
    bus.in_valid = 1'b1;
    bus.in_sop   = sop;
    bus.in_data  = DATA_W'(v);
    model_in(sop, v);
    cycle();
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  task automatic send_frame(input int base);
    send(1'b1, base);
    for (int i = 1; i < FRAME_LEN; i++) send(1'b0, base + i);
  endtask

  task automatic start_request();
    rx_ready = 1'b1;
    model_req();
    cycle();
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!frame_done && n < 100) begin
      cycle();
      n++;
    end
    check(name, int'(frame_done), 1);
  endtask

  task automatic wait_handshakes(input int cnt);
    int n;
    int h;
    n = 0;
    h = 0;
    while (h < cnt && n < 100) begin
      if (bus.out_valid && bus.out_ready) h++;
      cycle();
      n++;
    end
    check("handshake_budget", h, cnt);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"},  int'(bus.out_valid), 0);
    check({tag, "_out_last"},   int'(bus.out_last), 0);
    check({tag, "_uart_en"},    int'(uart_en), 0);
    check({tag, "_fill_count"}, int'(fill_count), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  // Per-cycle output checker against the model.
  logic              prev_stall, prev_last_hs, prev_lastbit, hs_now;
  logic [DATA_W-1:0] prev_data;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall   = 1'b0;
      prev_last_hs = 1'b0;
    end else begin
      check("frame_done_timing", int'(frame_done), int'(prev_last_hs));
      if (frame_done) check("valid_low_at_done", int'(bus.out_valid), 0);
      if (bus.out_valid) check("uart_en_with_valid", int'(uart_en), 1);
      if (prev_stall) begin
        check("stall_valid", int'(bus.out_valid), 1);
        check("stall_data", int'(bus.out_data), int'(prev_data));
        check("stall_last", int'(bus.out_last), int'(prev_lastbit));
      end
      hs_now = bus.out_valid & bus.out_ready & rx_ready;
      if (hs_now) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0d required=none",
                   int'($signed(bus.out_data)));
        end else begin
          int e;
          e = exp_q.pop_front();
          check("word_data", int'($signed(bus.out_data)), e);
          check("word_last", int'(bus.out_last), int'(exp_q.size() == 0));
        end
        got.push_back(int'($signed(bus.out_data)));
        words_seen++;
      end
      prev_stall   = bus.out_valid & ~bus.out_ready & rx_ready;
      prev_data    = bus.out_data;
      prev_lastbit = bus.out_last;
      prev_last_hs = hs_now & bus.out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int bp[FRAME_LEN];
  int lit[3];
  int w0;
  bit seen_first;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sop    = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bp = '{-5, 7, -128, 1, -1, 127, -127, 0};
`ifdef FFT_CAPTURE_ABS_EN
    lit = '{5, 7, 127};
`else
    lit = '{-5, 7, -128};
`endif
    #1 rst_n = 1'b0;
    cycle();
    cycle();
    check_idle_outputs("reset");
    check("reset_out_data", int'(bus.out_data), 0);
    check("reset_abort", int'(abort), 0);
    rst_n = 1'b1;
    cycle();

    // Basic frame with three leading non-sop samples.
    bus.out_ready = 1'b1;
    start_request();
    send(1'b0, 99);
    send(1'b0, 98);
    send(1'b0, 97);
    check("arm_ignores_non_sop", int'(fill_count), 0);
    w0 = words_seen;
    send_frame(10);
    check("fill_full", int'(fill_count), FRAME_LEN);
    check("drain_entry_uart_en", int'(uart_en), 1);
    check("drain_entry_no_valid", int'(bus.out_valid), 0);
    cycle();
    check("first_word_valid", int'(bus.out_valid), 1);
    check("first_word_data", int'($signed(bus.out_data)), 10);
    wait_done("basic_done");
    check("basic_words", words_seen - w0, 8);
    send(1'b1, 55);
    for (int i = 0; i < 3; i++) begin
      check("hold_uart_en", int'(uart_en), 0);
      check("hold_valid", int'(bus.out_valid), 0);
      check("hold_single_done", int'(frame_done), 0);
      check("hold_fill_count", int'(fill_count), FRAME_LEN);
      cycle();
    end
    rx_ready = 1'b0;
    cycle();
    check("release_fill_clear", int'(fill_count), 0);
    check("release_no_abort", int'(abort), 0);

    // Backpressure, also exercising signed extremes.
    bus.out_ready = 1'b0;
    start_request();
    for (int i = 0; i < FRAME_LEN; i++) send(i == 0, bp[i]);
    got.delete();
    w0 = words_seen;
    seen_first = 1'b0;
    for (int n = 0; n < 100 && !frame_done; n++) begin
      bus.out_ready = ~bus.out_ready;
      if (bus.out_valid && !seen_first) begin
        check("bp_first_word", int'($signed(bus.out_data)), lit[0]);
        seen_first = 1'b1;
      end
      cycle();
    end
    check("bp_done", int'(frame_done), 1);
    check("bp_words", words_seen - w0, 8);
    check("bp_got_size", got.size(), 8);
    if (got.size() == 8) begin
      for (int i = 0; i < 3; i++) check("bp_literal", got[i], lit[i]);
    end
    rx_ready = 1'b0;
    bus.out_ready = 1'b1;
    cycle();

    // Restart on a second sop.
    start_request();
    send(1'b1, 20);
    for (int i = 21; i <= 24; i++) send(1'b0, i);
    check("restart_fill5", int'(fill_count), 5);
    send(1'b1, 30);
    check("restart_fill1", int'(fill_count), 1);
    check("restart_no_abort", int'(abort), 0);
    for (int i = 31; i <= 37; i++) send(1'b0, i);
    got.delete();
    wait_done("restart_done");
    check("restart_got_size", got.size(), 8);
    if (got.size() == 8) begin
      check("restart_first", got[0], 30);
      check("restart_last", got[7], 37);
    end
    rx_ready = 1'b0;
    cycle();

    // Abort during FILL at fill_count 5, colliding with an input sample.
    start_request();
    send(1'b1, 40);
    for (int i = 41; i <= 44; i++) send(1'b0, i);
    check("abort_fill_count5", int'(fill_count), 5);
    rx_ready     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = DATA_W'(45);
    cycle();
    bus.in_valid = 1'b0;
    check("abort_fill_pulse", int'(abort), 1);
    check_idle_outputs("abort_fill");
    cycle();
    check("abort_fill_one_cycle", int'(abort), 0);

    // Abort during DRAIN after word 3.
    start_request();
    got.delete();
    send_frame(50);
    wait_handshakes(4);
    bus.out_ready = 1'b0;
    rx_ready      = 1'b0;
    exp_q.delete();
    cycle();
    check("abort_drain_pulse", int'(abort), 1);
    check_idle_outputs("abort_drain");
    check("abort_drain_got", got.size(), 4);
    if (got.size() == 4) check("abort_drain_word3", got[3], 53);
    cycle();
    check("abort_drain_one_cycle", int'(abort), 0);

    // Fresh request after aborts.
    bus.out_ready = 1'b1;
    start_request();
    got.delete();
    send_frame(60);
    wait_done("fresh_done");
    check("fresh_got_size", got.size(), 8);
    if (got.size() == 8) check("fresh_first", got[0], 60);
    rx_ready = 1'b0;
    cycle();
    check("queue_drained", exp_q.size(), 0);

    // Asynchronous reset mid-DRAIN.
    start_request();
    send_frame(70);
    wait_handshakes(2);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    check("rst_mid_out_data", int'(bus.out_data), 0);
    check("rst_mid_abort", int'(abort), 0);
    exp_q.delete();
    rx_ready = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check("post_reset_valid", int'(bus.out_valid), 0);
    check("post_reset_uart_en", int'(uart_en), 0);

    start_request();
    got.delete();
    send_frame(80);
    wait_done("post_reset_done");
    if (got.size() > 0) check("post_reset_first", got[0], 80);
    check("post_reset_got_size", got.size(), 8);
    rx_ready = 1'b0;
    cycle();
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
